// File: rtl/smvm_result_assembler_if.sv
// Host-side bundle for the SMVM result assembler:
// half-word input stream in, assembled result stream out.
interface smvm_result_assembler_if #(
    parameter int ROW_W = 8
);
    logic             in_valid;
    logic [13:0]      in_data;
    logic             res_valid;
    logic             res_ready;
    logic [27:0]      res_data;
    logic [ROW_W-1:0] res_row;
    logic             res_last;

    modport master (
        output in_valid, in_data, res_ready,
        input  res_valid, res_data, res_row, res_last
    );

    modport slave (
        input  in_valid, in_data, res_ready,
        output res_valid, res_data, res_row, res_last
    );
endinterface

// File: rtl/smvm_result_assembler.sv
// Re-pairs SMVM half-words into 28-bit results, tags them with
// a row index and queues them for the host behind a small FIFO.
module smvm_result_assembler #(
    parameter int DEPTH = 8,
    parameter int ROW_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ROW_W-1:0]      num_rows,
    smvm_result_assembler_if.slave bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DRAIN,
        S_FLUSH_DONE
    } state_t;

    state_t           r_state;
    logic [ROW_W-1:0] r_num_rows;
    logic [ROW_W-1:0] r_row_cnt;
    logic             r_phase;
    logic [13:0]      r_hi;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_done;
    logic             r_err;

    logic [27:0]      r_mem_data [DEPTH];
    logic [ROW_W-1:0] r_mem_row  [DEPTH];
    logic             r_mem_last [DEPTH];

    logic          w_valid;
    logic          w_pop;
    logic          w_full;
    logic          w_push;
    logic          w_wr;
    logic          w_drop;
    logic          w_last;
    logic [CW-1:0] w_cnt_nxt;

    assign w_valid   = (r_count != '0);
    assign w_pop     = w_valid && bus.res_ready;
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_push    = (r_state == S_COLLECT) && bus.in_valid
                       && r_phase && !start;
    // A full FIFO still accepts a push when the head leaves this cycle.
    assign w_wr      = w_push && (!w_full || w_pop);
    assign w_drop    = w_push && !w_wr;
    assign w_last    = (r_row_cnt == r_num_rows - ROW_W'(1));
    assign w_cnt_nxt = r_count + CW'(w_wr) - CW'(w_pop);

    assign bus.res_valid = w_valid;
    assign bus.res_data  = r_mem_data[r_rd_ptr];
    assign bus.res_row   = r_mem_row[r_rd_ptr];
    assign bus.res_last  = r_mem_last[r_rd_ptr];

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign err  = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_num_rows <= '0;
            r_row_cnt  <= '0;
            r_phase    <= 1'b0;
            r_hi       <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_row[i]  <= '0;
                r_mem_last[i] <= 1'b0;
            end
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_count    <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_row_cnt  <= '0;
                r_phase    <= 1'b0;
                r_err      <= 1'b0;
                r_num_rows <= num_rows;
                if (num_rows == '0) begin
                    r_state <= S_FLUSH_DONE;
                    r_done  <= 1'b1;
                end else begin
                    r_state <= S_COLLECT;
                end
            end else begin
                if (w_wr) begin
                    r_mem_data[r_wr_ptr] <= {r_hi, bus.in_data};
                    r_mem_row[r_wr_ptr]  <= r_row_cnt;
                    r_mem_last[r_wr_ptr] <= w_last;
                    r_wr_ptr             <= r_wr_ptr + AW'(1);
                end
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                r_count <= w_cnt_nxt;
                if (w_drop)
                    r_err <= 1'b1;

                unique case (r_state)
                    S_IDLE: ;
                    S_COLLECT: begin
                        if (bus.in_valid) begin
                            if (!r_phase) begin
                                r_hi    <= bus.in_data;
                                r_phase <= 1'b1;
                            end else begin
                                // Row count advances even on a drop.
                                r_phase   <= 1'b0;
                                r_row_cnt <= r_row_cnt + ROW_W'(1);
                                if (w_last)
                                    r_state <= S_DRAIN;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (bus.in_valid)
                            r_err <= 1'b1;
                        if ((r_count == '0) ||
                            (w_pop && r_count == CW'(1))) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                    S_FLUSH_DONE: r_state <= S_IDLE;
                    default:      r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_smvm_result_assembler.sv
// Directed bench for smvm_result_assembler: vector table for
// pairing/restart paths plus sequences for full and reset cases.
module tb_smvm_result_assembler;
    localparam int DEPTH = 8;
    localparam int ROW_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [ROW_W-1:0] num_rows = '0;
    logic             busy;
    logic             done;
    logic             err;

    smvm_result_assembler_if #(.ROW_W(ROW_W)) bus ();

    smvm_result_assembler #(
        .DEPTH(DEPTH),
        .ROW_W(ROW_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .num_rows(num_rows),
        .bus     (bus),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        st;
        logic [7:0]  nr;
        logic        v;
        logic [13:0] d;
        logic        rdy;
        logic        ev;
        logic [27:0] edata;
        logic [7:0]  erow;
        logic        elast;
        logic        ebusy;
        logic        edone;
        logic        eerr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic st, input logic [7:0] nr,
                       input logic v, input logic [13:0] d,
                       input logic rdy, input logic ev,
                       input logic [27:0] edata, input logic [7:0] erow,
                       input logic elast, input logic ebusy,
                       input logic edone, input logic eerr);
        vec_t t;
        t.st = st; t.nr = nr; t.v = v; t.d = d; t.rdy = rdy;
        t.ev = ev; t.edata = edata; t.erow = erow; t.elast = elast;
        t.ebusy = ebusy; t.edone = edone; t.eerr = eerr;
        tbl.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic st, input logic [7:0] nr,
                        input logic v, input logic [13:0] d,
                        input logic rdy);
        @(negedge clk);
        start = st;
        num_rows = nr;
        bus.in_valid = v;
        bus.in_data = d;
        bus.res_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [13:0] hi_of(input int r);
        return 14'(r * 37 + 8193);
    endfunction

    function automatic logic [13:0] lo_of(input int r);
        return 14'(r * 5 + 16);
    endfunction

    task automatic send_row(input int r, input logic rdy);
        step(1'b0, 8'd0, 1'b1, hi_of(r), rdy);
        step(1'b0, 8'd0, 1'b1, lo_of(r), rdy);
    endtask

    task automatic pop_row(input int r, input logic fin);
        @(negedge clk);
        chk($sformatf("pop%0d.valid", r), 32'(bus.res_valid), 32'd1);
        chk($sformatf("pop%0d.row", r), 32'(bus.res_row), 32'(r));
        chk($sformatf("pop%0d.data", r), 32'(bus.res_data),
            32'({hi_of(r), lo_of(r)}));
        chk($sformatf("pop%0d.last", r), 32'(bus.res_last), 32'd0);
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        chk($sformatf("pop%0d.done", r), 32'(done), 32'(fin));
        chk($sformatf("pop%0d.busy", r), 32'(busy), 32'(!fin));
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.res_ready = 1'b0;

        // basic pairing with hold under backpressure
        add(1, 2, 0, 14'h0000, 1, 0, 28'h0, 0, 0, 1, 0, 0);
        add(0, 0, 1, 14'h0000, 1, 0, 28'h0, 0, 0, 1, 0, 0);
        add(0, 0, 1, 14'h0005, 0, 1, 28'h0000005, 0, 0, 1, 0, 0);
        add(0, 0, 1, 14'h3FFF, 0, 1, 28'h0000005, 0, 0, 1, 0, 0);
        add(0, 0, 1, 14'h3FFE, 0, 1, 28'h0000005, 0, 0, 1, 0, 0);
        add(0, 0, 0, 14'h0000, 0, 1, 28'h0000005, 0, 0, 1, 0, 0);
        add(0, 0, 0, 14'h0000, 1, 1, 28'hFFFFFFE, 1, 1, 1, 0, 0);
        add(0, 0, 0, 14'h0000, 0, 1, 28'hFFFFFFE, 1, 1, 1, 0, 0);
        add(0, 0, 0, 14'h0000, 1, 0, 28'h0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 14'h0000, 0, 0, 28'h0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 14'h1234, 0, 0, 28'h0, 0, 0, 0, 0, 0);
        // gapped halves, extra word in drain, zero-row job
        add(1, 2, 0, 14'h0000, 1, 0, 28'h0, 0, 0, 1, 0, 0);
        add(0, 0, 1, 14'h0001, 1, 0, 28'h0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 14'h0000, 1, 0, 28'h0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 14'h0000, 1, 0, 28'h0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 14'h0000, 1, 0, 28'h0, 0, 0, 1, 0, 0);
        add(0, 0, 1, 14'h0002, 1, 1, 28'h0004002, 0, 0, 1, 0, 0);
        add(0, 0, 1, 14'h2000, 1, 0, 28'h0, 0, 0, 1, 0, 0);
        add(0, 0, 1, 14'h0001, 1, 1, 28'h8000001, 1, 1, 1, 0, 0);
        add(0, 0, 1, 14'h0AAA, 0, 1, 28'h8000001, 1, 1, 1, 0, 1);
        add(0, 0, 0, 14'h0000, 1, 0, 28'h0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 14'h0000, 0, 0, 28'h0, 0, 0, 0, 0, 1);
        add(1, 0, 0, 14'h0000, 0, 0, 28'h0, 0, 0, 1, 1, 0);
        add(0, 0, 0, 14'h0000, 0, 0, 28'h0, 0, 0, 0, 0, 0);
        // restart mid-collect after one HI word
        add(1, 1, 0, 14'h0000, 1, 0, 28'h0, 0, 0, 1, 0, 0);
        add(0, 0, 1, 14'h0111, 1, 0, 28'h0, 0, 0, 1, 0, 0);
        add(1, 1, 1, 14'h0222, 1, 0, 28'h0, 0, 0, 1, 0, 0);
        add(0, 0, 1, 14'h0003, 1, 0, 28'h0, 0, 0, 1, 0, 0);
        add(0, 0, 1, 14'h0004, 1, 1, 28'h000C004, 0, 1, 1, 0, 0);
        add(0, 0, 0, 14'h0000, 1, 0, 28'h0, 0, 0, 0, 1, 0);
        // restart with a queued entry flushes the FIFO
        add(1, 3, 0, 14'h0000, 0, 0, 28'h0, 0, 0, 1, 0, 0);
        add(0, 0, 1, 14'h0001, 0, 0, 28'h0, 0, 0, 1, 0, 0);
        add(0, 0, 1, 14'h0002, 0, 1, 28'h0004002, 0, 0, 1, 0, 0);
        add(1, 1, 0, 14'h0000, 0, 0, 28'h0, 0, 0, 1, 0, 0);
        add(0, 0, 1, 14'h0007, 0, 0, 28'h0, 0, 0, 1, 0, 0);
        add(0, 0, 1, 14'h0008, 0, 1, 28'h001C008, 0, 1, 1, 0, 0);
        add(0, 0, 0, 14'h0000, 1, 0, 28'h0, 0, 0, 0, 1, 0);

        #12;
        chk("rst.valid", 32'(bus.res_valid), 32'd0);
        chk("rst.data", 32'(bus.res_data), 32'd0);
        chk("rst.row", 32'(bus.res_row), 32'd0);
        chk("rst.last", 32'(bus.res_last), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].st, tbl[i].nr, tbl[i].v, tbl[i].d, tbl[i].rdy);
            chk($sformatf("v%0d.valid", i), 32'(bus.res_valid),
                32'(tbl[i].ev));
            chk($sformatf("v%0d.busy", i), 32'(busy), 32'(tbl[i].ebusy));
            chk($sformatf("v%0d.done", i), 32'(done), 32'(tbl[i].edone));
            chk($sformatf("v%0d.err", i), 32'(err), 32'(tbl[i].eerr));
            if (tbl[i].ev) begin
                chk($sformatf("v%0d.data", i), 32'(bus.res_data),
                    32'(tbl[i].edata));
                chk($sformatf("v%0d.row", i), 32'(bus.res_row),
                    32'(tbl[i].erow));
                chk($sformatf("v%0d.last", i), 32'(bus.res_last),
                    32'(tbl[i].elast));
            end
        end

        // overflow: rows 8 and 9 dropped, rows 0-7 drain in order
        step(1'b1, 8'd10, 1'b0, 14'h0, 1'b0);
        for (int r = 0; r < 10; r++) begin
            send_row(r, 1'b0);
            if (r == 7)
                chk("ovf.err_at_full", 32'(err), 32'd0);
        end
        chk("ovf.err", 32'(err), 32'd1);
        chk("ovf.busy", 32'(busy), 32'd1);
        for (int r = 0; r < 8; r++)
            pop_row(r, r == 7);
        step(1'b0, 8'd0, 1'b0, 14'h0, 1'b0);
        chk("ovf.done_once", 32'(done), 32'd0);

        // push and pop together at full
        step(1'b1, 8'd10, 1'b0, 14'h0, 1'b0);
        for (int r = 0; r < 8; r++)
            send_row(r, 1'b0);
        chk("pp.err_full", 32'(err), 32'd0);
        step(1'b0, 8'd0, 1'b1, hi_of(8), 1'b0);
        step(1'b0, 8'd0, 1'b1, lo_of(8), 1'b1);
        chk("pp.err", 32'(err), 32'd0);
        chk("pp.head", 32'(bus.res_row), 32'd1);
        send_row(9, 1'b0);
        chk("pp.still_full", 32'(err), 32'd1);
        for (int r = 1; r < 9; r++)
            pop_row(r, r == 8);

        // async reset with entries queued
        step(1'b1, 8'd5, 1'b0, 14'h0, 1'b0);
        for (int r = 0; r < 3; r++)
            send_row(r, 1'b0);
        chk("mid.valid", 32'(bus.res_valid), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid.rst_valid", 32'(bus.res_valid), 32'd0);
        chk("mid.rst_busy", 32'(busy), 32'd0);
        chk("mid.rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < 2; r++)
            send_row(r, 1'b0);
        chk("mid.ign_valid", 32'(bus.res_valid), 32'd0);
        chk("mid.ign_busy", 32'(busy), 32'd0);
        chk("mid.ign_err", 32'(err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
